// File: rtl/uart_command_decoder.sv
// Two-byte UART command decoder: command + address frame, one sensor access,
// then a two-byte reply (code, data) pushed to the transmitter.
module uart_command_decoder #(
  parameter int BYTE_TIMEOUT   = 1000000,
  parameter int SENSOR_TIMEOUT = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_has_data,
  input  logic [7:0] rx_data,
  input  logic       sensor_valid,
  input  logic       sensor_error,
  input  logic [7:0] sensor_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       sensor_request,
  output logic [7:0] request_command,
  output logic [4:0] request_address,
  output logic       tx_has_data,
  output logic [7:0] tx_data,
  output logic       frame_error,
  output logic       busy
);

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int SW = $clog2(SENSOR_TIMEOUT + 1);
  localparam logic [BW-1:0] BYTE_MAX    = BW'(BYTE_TIMEOUT);
  localparam logic [BW-1:0] BYTE_LAST   = BW'(BYTE_TIMEOUT - 1);
  localparam logic [SW-1:0] SENSOR_MAX  = SW'(SENSOR_TIMEOUT);
  localparam logic [SW-1:0] SENSOR_LAST = SW'(SENSOR_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_ADDR, CHECK, REQUEST, WAIT_SENSOR,
    SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [SW-1:0] sensor_cnt_q, sensor_cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [4:0]    addr_q, addr_d;
  logic          addr_hi_q, addr_hi_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_has_data_q, tx_has_data_d;
  logic          sensor_request_q, sensor_request_d;
  logic          frame_error_q, frame_error_d;
  logic          byte_timeout, sensor_timeout;

  assign byte_timeout   = (byte_cnt_q >= BYTE_LAST);
  assign sensor_timeout = (sensor_cnt_q >= SENSOR_LAST);

  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    addr_d           = addr_q;
    addr_hi_d        = addr_hi_q;
    code_d           = code_q;
    data_d           = data_q;
    tx_data_d        = tx_data_q;
    tx_has_data_d    = 1'b0;
    sensor_request_d = 1'b0;
    frame_error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_has_data) begin
          cmd_d   = rx_data;
          state_d = WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        // A byte arriving on the timeout cycle still completes the frame.
        if (rx_has_data) begin
          addr_d    = rx_data[4:0];
          addr_hi_d = |rx_data[7:5];
          state_d   = CHECK;
        end else if (byte_timeout) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end
      end
      CHECK: begin
        if (cmd_q <= 8'h06 && !addr_hi_q) begin
          sensor_request_d = 1'b1;
          state_d          = REQUEST;
        end else begin
          code_d  = 8'h1F;
          data_d  = 8'h00;
          state_d = SEND_CODE;
        end
      end
      REQUEST: state_d = WAIT_SENSOR;
      WAIT_SENSOR: begin
        if (sensor_valid) begin
          code_d  = sensor_error ? 8'h2F : cmd_q;
          data_d  = sensor_error ? 8'h00 : sensor_data;
          state_d = SEND_CODE;
        end else if (sensor_timeout) begin
          code_d  = 8'h3F;
          data_d  = 8'h00;
          state_d = SEND_CODE;
        end
      end
      SEND_CODE: begin
        if (!tx_busy) begin
          tx_data_d     = code_q;
          tx_has_data_d = 1'b1;
          state_d       = WAIT_CODE;
        end
      end
      WAIT_CODE: if (tx_done) state_d = SEND_DATA;
      SEND_DATA: begin
        if (!tx_busy) begin
          tx_data_d     = data_q;
          tx_has_data_d = 1'b1;
          state_d       = WAIT_DATA;
        end
      end
      WAIT_DATA: if (tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (rx_has_data && state_q != IDLE && state_q != WAIT_ADDR) begin
      frame_error_d = 1'b1;
    end

    // Counters run only while staying in their state, so any entry restarts them at zero.
    byte_cnt_d = '0;
    if (state_q == WAIT_ADDR && state_d == WAIT_ADDR) begin
      byte_cnt_d = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q : byte_cnt_q + BW'(1);
    end
    sensor_cnt_d = '0;
    if (state_q == WAIT_SENSOR && state_d == WAIT_SENSOR) begin
      sensor_cnt_d = (sensor_cnt_q == SENSOR_MAX) ? sensor_cnt_q : sensor_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= IDLE;
      byte_cnt_q       <= '0;
      sensor_cnt_q     <= '0;
      cmd_q            <= '0;
      addr_q           <= '0;
      addr_hi_q        <= 1'b0;
      code_q           <= '0;
      data_q           <= '0;
      tx_data_q        <= '0;
      tx_has_data_q    <= 1'b0;
      sensor_request_q <= 1'b0;
      frame_error_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      sensor_cnt_q     <= sensor_cnt_d;
      cmd_q            <= cmd_d;
      addr_q           <= addr_d;
      addr_hi_q        <= addr_hi_d;
      code_q           <= code_d;
      data_q           <= data_d;
      tx_data_q        <= tx_data_d;
      tx_has_data_q    <= tx_has_data_d;
      sensor_request_q <= sensor_request_d;
      frame_error_q    <= frame_error_d;
    end
  end

  assign sensor_request  = sensor_request_q;
  assign request_command = cmd_q;
  assign request_address = addr_q;
  assign tx_has_data     = tx_has_data_q;
  assign tx_data         = tx_data_q;
  assign frame_error     = frame_error_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_command_decoder.sv
// Bench for uart_command_decoder: a frame-level reply model feeds expected-byte
// queues that one negedge compare process checks, plus literal timing pins.
module tb_uart_command_decoder;

  localparam int BT  = 20;
  localparam int ST  = 40;
  localparam int OK  = 0;
  localparam int ERR = 1;
  localparam int TMO = 2;
  localparam logic [7:0] BAD_CMD  [3] = '{8'h09, 8'h03, 8'h07};
  localparam logic [7:0] BAD_ADDR [3] = '{8'h02, 8'hE4, 8'h00};

  logic clock = 1'b0;
  logic reset, rx_has_data, sensor_valid, sensor_error, tx_done;
  logic [7:0] rx_data, sensor_data;
  logic txBusyAuto, txBusyHold, tx_busy;
  logic sensor_request, tx_has_data, frame_error, busy;
  logic [7:0] request_command, tx_data;
  logic [4:0] request_address;

  assign tx_busy = txBusyAuto | txBusyHold;

  uart_command_decoder #(.BYTE_TIMEOUT(BT), .SENSOR_TIMEOUT(ST)) dut (
    .clock(clock), .reset(reset), .rx_has_data(rx_has_data), .rx_data(rx_data),
    .sensor_valid(sensor_valid), .sensor_error(sensor_error), .sensor_data(sensor_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .sensor_request(sensor_request),
    .request_command(request_command), .request_address(request_address),
    .tx_has_data(tx_has_data), .tx_data(tx_data), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  logic rstAtEdge = 1'b0;

  always @(posedge clock) begin
    cycle     <= cycle + 1;
    rstAtEdge <= ~reset;
  end

  logic [7:0]  expTx  [0:255];
  logic [12:0] expReq [0:255];
  logic [7:0]  txLog  [0:255];
  int expTxWr = 0, expTxRd = 0, expReqWr = 0, expReqRd = 0;
  int txCount = 0, reqCount = 0, feCount = 0;
  int lastTxCycle = 0, lastReqCycle = 0, lastFeCycle = 0, lastDoneEdge = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  function automatic logic frameValid(input logic [7:0] cmd, input logic [7:0] addrByte);
    return (cmd <= 8'h06) && (addrByte[7:5] == 3'b000);
  endfunction

  function automatic logic [15:0] modelResponse(input logic [7:0] cmd, input logic [7:0] addrByte,
                                                input int kind, input logic [7:0] data);
    if (!frameValid(cmd, addrByte)) return 16'h1F00;
    case (kind)
      ERR:     return 16'h2F00;
      TMO:     return 16'h3F00;
      default: return {cmd, data};
    endcase
  endfunction

  task automatic expectFrame(input logic [7:0] cmd, input logic [7:0] addrByte,
                             input int kind, input logic [7:0] data);
    logic [15:0] r;
    r = modelResponse(cmd, addrByte, kind, data);
    if (frameValid(cmd, addrByte)) begin
      expReq[expReqWr] = {cmd, addrByte[4:0]};
      expReqWr++;
    end
    expTx[expTxWr]     = r[15:8];
    expTx[expTxWr + 1] = r[7:0];
    expTxWr += 2;
  endtask

  // Compare process: every pulse is matched against the model queues.
  logic prevReq = 1'b0, prevTx = 1'b0;
  logic [7:0] lastTx = 8'h00;
  always @(negedge clock) begin
    if (rstAtEdge) begin
      checkOutput("reset_outputs", {sensor_request, tx_has_data, frame_error, busy,
                                    request_command, request_address, tx_data}, 32'd0);
      lastTx = 8'h00;
    end else begin
      if (sensor_request) begin
        lastReqCycle = cycle;
        reqCount++;
        checkOutput("sensor_request_width", {31'd0, prevReq}, 32'd0);
        if (expReqRd >= expReqWr)
          flagFail("sensor_request", $sformatf("got pulse cmd/addr 0x%0h, expected none",
                                               {request_command, request_address}));
        else begin
          checkOutput("request_fields", {request_command, request_address}, expReq[expReqRd]);
          expReqRd++;
        end
      end
      if (tx_has_data) begin
        lastTxCycle = cycle;
        txLog[txCount] = tx_data;
        txCount++;
        lastTx = tx_data;
        checkOutput("tx_has_data_width", {31'd0, prevTx}, 32'd0);
        if (expTxRd >= expTxWr)
          flagFail("tx_byte", $sformatf("got byte 0x%0h, expected no transmit", tx_data));
        else begin
          checkOutput("tx_byte", tx_data, expTx[expTxRd]);
          expTxRd++;
        end
      end else begin
        checkOutput("tx_data_hold", tx_data, lastTx);
      end
      if (frame_error) begin
        lastFeCycle = cycle;
        feCount++;
      end
    end
    prevReq = sensor_request;
    prevTx  = tx_has_data;
  end

  // Transmitter stand-in: busy for four cycles after each start, then tx_done.
  initial begin
    txBusyAuto = 1'b0;
    tx_done    = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_has_data) begin
        @(posedge clock); #1 txBusyAuto = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        txBusyAuto   = 1'b0;
        tx_done      = 1'b1;
        lastDoneEdge = cycle + 1;
        @(posedge clock); #1 tx_done = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, output int sampleEdge);
    rx_has_data = 1'b1;
    rx_data     = b;
    tick();
    sampleEdge  = cycle;
    rx_has_data = 1'b0;
    rx_data     = 8'h00;
  endtask

  task automatic pulseSensor(input logic err, input logic [7:0] data);
    sensor_valid = 1'b1;
    sensor_error = err;
    sensor_data  = data;
    tick();
    sensor_valid = 1'b0;
    sensor_error = 1'b0;
    sensor_data  = 8'h00;
  endtask

  task automatic waitReq(input int target, input int maxCycles);
    int n = 0;
    while (reqCount < target && n < maxCycles) begin tick(); n++; end
    if (reqCount < target)
      flagFail("wait_sensor_request", $sformatf("got %0d requests, expected %0d", reqCount, target));
  endtask

  task automatic waitTx(input int target, input int maxCycles);
    int n = 0;
    while (txCount < target && n < maxCycles) begin tick(); n++; end
    if (txCount < target)
      flagFail("wait_tx", $sformatf("got %0d transmits, expected %0d", txCount, target));
  endtask

  task automatic finishFrame(input int tx0);
    int n = 0;
    waitTx(tx0 + 2, 200);
    while (busy && n < 50) begin tick(); n++; end
    checkOutput("busy_falls", {31'd0, busy}, 32'd0);
    checkOutput("busy_fall_edge", cycle, lastDoneEdge);
  endtask

  task automatic checkDrained;
    checkOutput("tx_queue_drained", expTxRd, expTxWr);
    checkOutput("req_queue_drained", expReqRd, expReqWr);
  endtask

  task automatic runValid(input logic [7:0] cmd, input logic [7:0] addrByte,
                          input int kind, input logic [7:0] data);
    int e, tx0, req0;
    tx0  = txCount;
    req0 = reqCount;
    expectFrame(cmd, addrByte, kind, data);
    applyStimulus(cmd, e);
    applyStimulus(addrByte, e);
    waitReq(req0 + 1, 10);
    pulseSensor(kind == ERR, data);
    finishFrame(tx0);
  endtask

  initial begin
    int e0, e1, r, tx0, req0, fe0, n;
    reset = 1'b0; rx_has_data = 1'b0; rx_data = 8'h00;
    sensor_valid = 1'b0; sensor_error = 1'b0; sensor_data = 8'h00; txBusyHold = 1'b0;
    repeat (3) tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // Nominal frame 0x01/0x05 with sensor data 0x1A.
    fe0 = feCount; tx0 = txCount; req0 = reqCount;
    expectFrame(8'h01, 8'h05, OK, 8'h1A);
    applyStimulus(8'h01, e0);
    applyStimulus(8'h05, e1);
    waitReq(req0 + 1, 10);
    checkOutput("t1_request_edge", lastReqCycle + 1, e1 + 2);
    checkOutput("t1_request_address", request_address, 32'h05);
    checkOutput("t1_request_command", request_command, 32'h01);
    pulseSensor(1'b0, 8'h1A);
    finishFrame(tx0);
    checkOutput("t1_code_byte", txLog[tx0], 32'h01);
    checkOutput("t1_data_byte", txLog[tx0 + 1], 32'h1A);
    checkOutput("t1_no_frame_error", feCount - fe0, 32'd0);
    checkDrained();

    // Invalid frames: command above 0x06 or address upper bits set.
    for (int i = 0; i < 3; i++) begin
      tx0 = txCount; req0 = reqCount;
      expectFrame(BAD_CMD[i], BAD_ADDR[i], OK, 8'h00);
      applyStimulus(BAD_CMD[i], e0);
      applyStimulus(BAD_ADDR[i], e1);
      finishFrame(tx0);
      checkOutput("t2_no_request", reqCount, req0);
      checkOutput("t2_code_byte", txLog[tx0], 32'h1F);
      checkOutput("t2_data_byte", txLog[tx0 + 1], 32'h00);
    end
    checkDrained();

    runValid(8'h06, 8'h00, OK, 8'hC3);
    checkOutput("t2_edge_cmd6_data", txLog[txCount - 1], 32'hC3);

    // Address-byte timeout, then a normal frame.
    fe0 = feCount;
    applyStimulus(8'h02, e0);
    n = 0;
    while (feCount == fe0 && n < BT + 10) begin tick(); n++; end
    checkOutput("t3_timeout_pulses", feCount - fe0, 32'd1);
    checkOutput("t3_timeout_edge", lastFeCycle, e0 + BT);
    checkOutput("t3_idle_after_timeout", {31'd0, busy}, 32'd0);
    runValid(8'h02, 8'h03, OK, 8'h77);
    checkOutput("t3_next_frame_data", txLog[txCount - 1], 32'h77);

    // Address byte on the exact timeout cycle wins.
    fe0 = feCount;
    applyStimulus(8'h04, e0);
    while (cycle < e0 + BT - 1) tick();
    tx0 = txCount; req0 = reqCount;
    expectFrame(8'h04, 8'h06, OK, 8'h3C);
    applyStimulus(8'h06, e1);
    checkOutput("t3b_byte_edge", e1, e0 + BT);
    waitReq(req0 + 1, 10);
    pulseSensor(1'b0, 8'h3C);
    finishFrame(tx0);
    checkOutput("t3b_no_frame_error", feCount - fe0, 32'd0);
    checkDrained();

    // Sensor timeout; late sensor_valid pulses are ignored.
    tx0 = txCount; req0 = reqCount;
    expectFrame(8'h05, 8'h1F, TMO, 8'h00);
    applyStimulus(8'h05, e0);
    applyStimulus(8'h1F, e1);
    waitReq(req0 + 1, 10);
    r = lastReqCycle + 1;
    waitTx(tx0 + 1, ST + 20);
    checkOutput("t4_timeout_tx_edge", lastTxCycle, r + ST + 1);
    pulseSensor(1'b0, 8'h99);
    finishFrame(tx0);
    checkOutput("t4_code_byte", txLog[tx0], 32'h3F);
    checkOutput("t4_data_byte", txLog[tx0 + 1], 32'h00);
    pulseSensor(1'b0, 8'h99);
    tick();
    checkOutput("t4_idle_ignores_sensor", {31'd0, busy}, 32'd0);
    checkDrained();

    // sensor_valid on the timeout cycle wins; sensor_error reply.
    tx0 = txCount; req0 = reqCount;
    expectFrame(8'h01, 8'h01, OK, 8'h44);
    applyStimulus(8'h01, e0);
    applyStimulus(8'h01, e1);
    waitReq(req0 + 1, 10);
    r = lastReqCycle + 1;
    while (cycle < r + ST - 1) tick();
    pulseSensor(1'b0, 8'h44);
    finishFrame(tx0);
    checkOutput("t4b_data_byte", txLog[tx0 + 1], 32'h44);
    runValid(8'h03, 8'h07, ERR, 8'h55);
    checkOutput("t4c_error_code", txLog[txCount - 2], 32'h2F);
    checkDrained();

    // Transmitter held busy in SEND_CODE; stray byte during WAIT_SENSOR.
    fe0 = feCount; tx0 = txCount; req0 = reqCount;
    expectFrame(8'h02, 8'h09, OK, 8'h5A);
    applyStimulus(8'h02, e0);
    applyStimulus(8'h09, e1);
    waitReq(req0 + 1, 10);
    txBusyHold = 1'b1;
    applyStimulus(8'hAB, e0);
    pulseSensor(1'b0, 8'h5A);
    repeat (10) tick();
    checkOutput("t5_no_tx_while_busy", txCount, tx0);
    txBusyHold = 1'b0;
    e0 = cycle;
    waitTx(tx0 + 1, 10);
    checkOutput("t5_tx_after_busy_edge", lastTxCycle, e0 + 1);
    finishFrame(tx0);
    checkOutput("t5_stray_frame_error", feCount - fe0, 32'd1);
    checkOutput("t5_data_unchanged", txLog[tx0 + 1], 32'h5A);
    checkDrained();

    // Reset during WAIT_DATA, then a frame right on release.
    tx0 = txCount; req0 = reqCount;
    expectFrame(8'h03, 8'h04, OK, 8'h21);
    applyStimulus(8'h03, e0);
    applyStimulus(8'h04, e1);
    waitReq(req0 + 1, 10);
    pulseSensor(1'b0, 8'h21);
    waitTx(tx0 + 2, 50);
    reset = 1'b0;
    repeat (6) tick();
    checkOutput("t6_no_tx_in_reset", txCount, tx0 + 2);
    checkOutput("t6_no_request_in_reset", reqCount, req0 + 1);
    checkDrained();
    tx0 = txCount;
    expectFrame(8'h00, 8'h00, OK, 8'h66);
    reset = 1'b1;
    applyStimulus(8'h00, e0);
    applyStimulus(8'h00, e1);
    waitReq(req0 + 2, 10);
    pulseSensor(1'b0, 8'h66);
    finishFrame(tx0);
    checkOutput("t6_code_byte", txLog[tx0], 32'h00);
    checkOutput("t6_data_byte", txLog[tx0 + 1], 32'h66);
    checkDrained();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got no completion by 200000ns, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
